id_ex_pipe: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. Sits directly downstream of the main control decoder and register file. Each cycle it captures the decoder's control bits and the ID-stage operands, and presents them to the EX stage. It detects a load-use dependency, inserts a bubble, and tells IF/ID to hold. It also squashes the ID instruction on a taken-branch flush.

---
 rtl/id_ex_pipe_if.sv | 42 ++++
 rtl/id_ex_pipe.sv | 92 +++++++++
 tb/tb_id_ex_pipe.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_if.sv
// rtl/id_ex_pipe_if.sv - ID-to-EX bundle: decoder/operand inputs, EX-side copies, hazard outputs
interface id_ex_pipe_if #(
    parameter int W  = 32,
    parameter int CW = 16
);
    logic          id_regdst, id_alusrc, id_branch, id_memread;
    logic          id_memwrite, id_regwrite, id_memtoreg;
    logic [1:0]    id_aluop;
    logic [W-1:0]  id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic [5:0]    id_funct;
    logic          id_valid;
    logic          flush;

    logic          ex_regdst, ex_alusrc, ex_branch, ex_memread;
    logic          ex_memwrite, ex_regwrite, ex_memtoreg;
    logic [1:0]    ex_aluop;
    logic [W-1:0]  ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic [5:0]    ex_funct;
    logic          ex_valid;
    logic          stall, pc_write, ifid_write;
    logic [CW-1:0] bubble_cnt;

    modport master (
        output id_regdst, id_alusrc, id_branch, id_memread, id_memwrite, id_regwrite, id_memtoreg,
               id_aluop, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct,
               id_valid, flush,
        input  ex_regdst, ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg,
               ex_aluop, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
               ex_valid, stall, pc_write, ifid_write, bubble_cnt
    );

    modport slave (
        input  id_regdst, id_alusrc, id_branch, id_memread, id_memwrite, id_regwrite, id_memtoreg,
               id_aluop, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct,
               id_valid, flush,
        output ex_regdst, ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg,
               ex_aluop, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
               ex_valid, stall, pc_write, ifid_write, bubble_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use hazard detection and bubble insertion
module id_ex_pipe #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_pipe_if.slave  bus
);
    localparam logic [CW-1:0] CNT_MAX = '1;

    // control vector order: {regdst, alusrc, branch, memread, memwrite, regwrite, memtoreg}
    logic [6:0]    ctrl_q;
    logic [1:0]    aluop_q;
    logic [W-1:0]  pc4_q, rd1_q, rd2_q, imm_q;
    logic [4:0]    rs_q, rt_q, rd_q;
    logic [5:0]    funct_q;
    logic          valid_q;
    logic [CW-1:0] cnt_q;

    logic [6:0]    id_ctrl;
    logic          uses_rt;
    logic          hazard;
    logic          stall;
    logic          bubble;

    assign id_ctrl = {bus.id_regdst, bus.id_alusrc, bus.id_branch, bus.id_memread,
                      bus.id_memwrite, bus.id_regwrite, bus.id_memtoreg};

    // rt is a source only for R-type, stores and branches
    assign uses_rt = bus.id_regdst | bus.id_memwrite | bus.id_branch;
    assign hazard  = valid_q & ctrl_q[3] & bus.id_valid & (rt_q != 5'd0) &
                     ((rt_q == bus.id_rs) | (uses_rt & (rt_q == bus.id_rt)));
    // a flushed consumer is dead, so it never needs to wait for the load
    assign stall   = hazard & ~bus.flush;
    assign bubble  = bus.flush | stall | ~bus.id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= '0;
            aluop_q <= '0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            funct_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // data fields load unconditionally; a bubble only kills control and validity
            pc4_q   <= bus.id_pc4;
            rd1_q   <= bus.id_rd1;
            rd2_q   <= bus.id_rd2;
            imm_q   <= bus.id_imm;
            rs_q    <= bus.id_rs;
            rt_q    <= bus.id_rt;
            rd_q    <= bus.id_rd;
            funct_q <= bus.id_funct;
            ctrl_q  <= bubble ? 7'd0 : id_ctrl;
            aluop_q <= bubble ? 2'd0 : bus.id_aluop;
            valid_q <= ~bubble;
            if ((stall | bus.flush) && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign bus.ex_regdst   = ctrl_q[6];
    assign bus.ex_alusrc   = ctrl_q[5];
    assign bus.ex_branch   = ctrl_q[4];
    assign bus.ex_memread  = ctrl_q[3];
    assign bus.ex_memwrite = ctrl_q[2];
    assign bus.ex_regwrite = ctrl_q[1];
    assign bus.ex_memtoreg = ctrl_q[0];
    assign bus.ex_aluop    = aluop_q;
    assign bus.ex_pc4      = pc4_q;
    assign bus.ex_rd1      = rd1_q;
    assign bus.ex_rd2      = rd2_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_rs       = rs_q;
    assign bus.ex_rt       = rt_q;
    assign bus.ex_rd       = rd_q;
    assign bus.ex_funct    = funct_q;
    assign bus.ex_valid    = valid_q;
    assign bus.stall       = stall;
    assign bus.pc_write    = ~stall;
    assign bus.ifid_write  = ~stall;
    assign bus.bubble_cnt  = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - table-driven bench for id_ex_pipe plus counter saturation sequence
module tb_id_ex_pipe;
    logic clk;
    logic rst;
    logic srst;

    id_ex_pipe_if #(.W(32), .CW(16)) bus ();
    id_ex_pipe_if #(.W(32), .CW(4))  sbus ();

    id_ex_pipe #(.W(32), .CW(16)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    id_ex_pipe #(.W(32), .CW(4))  sdut (.clk(clk), .rst(srst), .bus(sbus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        flush;
        logic        valid;
        logic [6:0]  c;
        logic [1:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rd1;
        logic        chk_comb;
        logic        exp_stall;
        logic [6:0]  ec;
        logic [1:0]  eop;
        logic        ev;
        logic [15:0] ecnt;
    } vec_t;

    localparam logic [6:0] R = 7'b1000011;
    localparam logic [6:0] L = 7'b0101010;
    localparam logic [6:0] A = 7'b0100011;
    localparam logic [6:0] S = 7'b0100100;
    localparam logic [6:0] Z = 7'b0000000;

    vec_t vecs [23];
    int total = 0;
    int bad = 0;

    function automatic vec_t mk(input logic r, input logic f, input logic v, input logic [6:0] c,
                                input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] rd1, input logic cc,
                                input logic es, input logic [6:0] ec, input logic [1:0] eop,
                                input logic ev, input logic [15:0] ecnt);
        vec_t t;
        t.rst = r; t.flush = f; t.valid = v; t.c = c; t.op = op;
        t.rs = rs; t.rt = rt; t.rd = rd; t.rd1 = rd1;
        t.chk_comb = cc; t.exp_stall = es; t.ec = ec; t.eop = eop; t.ev = ev; t.ecnt = ecnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        rst             = t.rst;
        bus.flush       = t.flush;
        bus.id_valid    = t.valid;
        {bus.id_regdst, bus.id_alusrc, bus.id_branch, bus.id_memread,
         bus.id_memwrite, bus.id_regwrite, bus.id_memtoreg} = t.c;
        bus.id_aluop    = t.op;
        bus.id_rs       = t.rs;
        bus.id_rt       = t.rt;
        bus.id_rd       = t.rd;
        bus.id_rd1      = t.rd1;
        bus.id_rd2      = t.rd1 + 32'h1000;
        bus.id_imm      = {27'd0, t.rd} + 32'h40;
        bus.id_pc4      = t.rd1 ^ 32'hA5A5_0000;
        bus.id_funct    = {1'b0, t.rd};
    endtask

    initial begin
        logic [31:0] e_rd1, e_rd2, e_imm, e_pc4;
        logic [4:0]  e_rs, e_rt, e_rd;
        logic [5:0]  e_fn;
        logic [6:0]  act_c;
        logic [3:0]  sexp;

        vecs[0]  = mk(1,0,1,R,2'b10, 1, 2,3,32'h55 ,0,0,Z,2'b00,0,0);
        vecs[1]  = mk(1,0,1,L,2'b00, 0, 5,0,32'h66 ,1,0,Z,2'b00,0,0);
        vecs[2]  = mk(0,0,1,R,2'b10, 1, 2,3,32'h10 ,1,0,R,2'b10,1,0);
        vecs[3]  = mk(0,0,1,L,2'b00, 1, 5,0,32'h100,1,0,L,2'b00,1,0);
        vecs[4]  = mk(0,0,1,R,2'b10, 5, 6,7,32'h11 ,1,1,Z,2'b00,0,1);
        vecs[5]  = mk(0,0,1,R,2'b10, 5, 6,7,32'h11 ,1,0,R,2'b10,1,1);
        vecs[6]  = mk(0,0,1,L,2'b00, 2, 0,0,32'h200,1,0,L,2'b00,1,1);
        vecs[7]  = mk(0,0,1,R,2'b10, 0, 0,4,32'h12 ,1,0,R,2'b10,1,1);
        vecs[8]  = mk(0,0,1,L,2'b00, 3, 7,0,32'h300,1,0,L,2'b00,1,1);
        vecs[9]  = mk(0,0,1,A,2'b00, 1, 7,0,32'h13 ,1,0,A,2'b00,1,1);
        vecs[10] = mk(0,0,1,L,2'b00, 2, 8,0,32'h400,1,0,L,2'b00,1,1);
        vecs[11] = mk(0,0,1,S,2'b00, 1, 8,0,32'h14 ,1,1,Z,2'b00,0,2);
        vecs[12] = mk(0,0,1,S,2'b00, 1, 8,0,32'h14 ,1,0,S,2'b00,1,2);
        vecs[13] = mk(0,0,1,L,2'b00, 1, 9,0,32'h500,1,0,L,2'b00,1,2);
        vecs[14] = mk(0,1,1,R,2'b10, 9, 1,2,32'h15 ,1,0,Z,2'b00,0,3);
        vecs[15] = mk(0,0,1,L,2'b00, 0,10,0,32'h600,1,0,L,2'b00,1,3);
        vecs[16] = mk(0,0,1,L,2'b00,10,11,0,32'h700,1,1,Z,2'b00,0,4);
        vecs[17] = mk(0,0,1,L,2'b00,10,11,0,32'h700,1,0,L,2'b00,1,4);
        vecs[18] = mk(0,0,0,R,2'b10,11, 1,2,32'h16 ,1,0,Z,2'b00,0,4);
        vecs[19] = mk(0,0,1,R,2'b10,11, 1,2,32'h16 ,1,0,R,2'b10,1,4);
        vecs[20] = mk(0,0,1,L,2'b00, 1,12,0,32'h800,1,0,L,2'b00,1,4);
        vecs[21] = mk(1,0,1,R,2'b10,12, 1,2,32'h17 ,1,1,Z,2'b00,0,0);
        vecs[22] = mk(0,0,1,R,2'b10,12, 1,2,32'h17 ,1,0,R,2'b10,1,0);

        srst = 1'b1;
        sbus.flush = 1'b0; sbus.id_valid = 1'b1;
        {sbus.id_regdst, sbus.id_alusrc, sbus.id_branch, sbus.id_memread,
         sbus.id_memwrite, sbus.id_regwrite, sbus.id_memtoreg} = 7'd0;
        sbus.id_aluop = 2'd0; sbus.id_pc4 = 32'd0; sbus.id_rd1 = 32'd0; sbus.id_rd2 = 32'd0;
        sbus.id_imm = 32'd0; sbus.id_rs = 5'd0; sbus.id_rt = 5'd0; sbus.id_rd = 5'd0;
        sbus.id_funct = 6'd0;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            if (vecs[i].chk_comb) begin
                chk($sformatf("v%0d stall", i), {31'd0, bus.stall}, {31'd0, vecs[i].exp_stall});
                chk($sformatf("v%0d pc_write", i), {31'd0, bus.pc_write}, {31'd0, ~vecs[i].exp_stall});
                chk($sformatf("v%0d ifid_write", i), {31'd0, bus.ifid_write}, {31'd0, ~vecs[i].exp_stall});
            end
            @(posedge clk);
            #1;
            act_c = {bus.ex_regdst, bus.ex_alusrc, bus.ex_branch, bus.ex_memread,
                     bus.ex_memwrite, bus.ex_regwrite, bus.ex_memtoreg};
            chk($sformatf("v%0d ex_ctrl", i), {25'd0, act_c}, {25'd0, vecs[i].ec});
            chk($sformatf("v%0d ex_aluop", i), {30'd0, bus.ex_aluop}, {30'd0, vecs[i].eop});
            chk($sformatf("v%0d ex_valid", i), {31'd0, bus.ex_valid}, {31'd0, vecs[i].ev});
            chk($sformatf("v%0d bubble_cnt", i), {16'd0, bus.bubble_cnt}, {16'd0, vecs[i].ecnt});
            if (vecs[i].rst || vecs[i].ev) begin
                e_rd1 = vecs[i].rst ? 32'd0 : vecs[i].rd1;
                e_rd2 = vecs[i].rst ? 32'd0 : vecs[i].rd1 + 32'h1000;
                e_imm = vecs[i].rst ? 32'd0 : {27'd0, vecs[i].rd} + 32'h40;
                e_pc4 = vecs[i].rst ? 32'd0 : vecs[i].rd1 ^ 32'hA5A5_0000;
                e_rs  = vecs[i].rst ? 5'd0 : vecs[i].rs;
                e_rt  = vecs[i].rst ? 5'd0 : vecs[i].rt;
                e_rd  = vecs[i].rst ? 5'd0 : vecs[i].rd;
                e_fn  = vecs[i].rst ? 6'd0 : {1'b0, vecs[i].rd};
                chk($sformatf("v%0d ex_rd1", i), bus.ex_rd1, e_rd1);
                chk($sformatf("v%0d ex_rd2", i), bus.ex_rd2, e_rd2);
                chk($sformatf("v%0d ex_imm", i), bus.ex_imm, e_imm);
                chk($sformatf("v%0d ex_pc4", i), bus.ex_pc4, e_pc4);
                chk($sformatf("v%0d ex_rs", i), {27'd0, bus.ex_rs}, {27'd0, e_rs});
                chk($sformatf("v%0d ex_rt", i), {27'd0, bus.ex_rt}, {27'd0, e_rt});
                chk($sformatf("v%0d ex_rd", i), {27'd0, bus.ex_rd}, {27'd0, e_rd});
                chk($sformatf("v%0d ex_funct", i), {26'd0, bus.ex_funct}, {26'd0, e_fn});
            end
        end

        // saturation on the narrow counter instance
        @(negedge clk);
        srst = 1'b1; sbus.flush = 1'b0;
        @(posedge clk); #1;
        chk("sat reset cnt", {28'd0, sbus.bubble_cnt}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            srst = 1'b0; sbus.flush = 1'b1;
            #1;
            chk($sformatf("sat%0d stall", k), {31'd0, sbus.stall}, 32'd0);
            @(posedge clk); #1;
            sexp = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
            chk($sformatf("sat%0d cnt", k), {28'd0, sbus.bubble_cnt}, {28'd0, sexp});
            chk($sformatf("sat%0d ex_valid", k), {31'd0, sbus.ex_valid}, 32'd0);
        end
        @(negedge clk);
        srst = 1'b1;
        @(posedge clk); #1;
        chk("sat post-reset cnt", {28'd0, sbus.bubble_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
